// File: rtl/axis_rr_arbiter_pkg.sv
// rtl/axis_rr_arbiter_pkg.sv - shared widths, ID-width helper and drop-counter saturation constant
package axis_rr_arbiter_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    // Saturation value of the drop counter at its default width
    localparam logic [DEF_CNT_WIDTH-1:0] DROP_SAT = {DEF_CNT_WIDTH{1'b1}};

    // Width of a channel index; never narrower than one bit
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - input beats and merged output stream of the arbiter
interface axis_rr_arbiter_if
    import axis_rr_arbiter_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    localparam int IDW = id_width(NUM_CH);

    logic [NUM_CH*DATA_WIDTH-1:0] S_AXIS_tdata;
    logic [NUM_CH-1:0]            S_AXIS_tvalid;
    logic [DATA_WIDTH-1:0]        M_AXIS_tdata;
    logic                         M_AXIS_tvalid;
    logic [IDW-1:0]               M_AXIS_tid;

    // Arbiter side: consumes the per-channel beats, produces the merged stream
    modport slave (
        input  S_AXIS_tdata,
        input  S_AXIS_tvalid,
        output M_AXIS_tdata,
        output M_AXIS_tvalid,
        output M_AXIS_tid
    );

    // Environment side: sources the beats, observes the merged stream
    modport master (
        output S_AXIS_tdata,
        output S_AXIS_tvalid,
        input  M_AXIS_tdata,
        input  M_AXIS_tvalid,
        input  M_AXIS_tid
    );

endinterface

// File: rtl/axis_rr_arbiter_rr_priority_pick.sv
// rtl/axis_rr_arbiter_rr_priority_pick.sv - first pending index at or after ptr, modulo NUM_CH
module rr_priority_pick
    import axis_rr_arbiter_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic [NUM_CH-1:0]           pending,
    input  logic [id_width(NUM_CH)-1:0] ptr,
    output logic                        grant_valid,
    output logic [id_width(NUM_CH)-1:0] grant_idx
);

    localparam int IDW = id_width(NUM_CH);

    // Walk upward from ptr, wrapping, and keep the first pending channel found
    always_comb begin
        logic [31:0]    idx;
        logic [IDW-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx  = (32'(ptr) + 32'(i)) % 32'(NUM_CH);
            cand = idx[IDW-1:0];
            if (!grant_valid && pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - round-robin merge of tvalid-only streams with overwrite accounting
module axis_rr_arbiter
    import axis_rr_arbiter_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  a_clk,
    input  logic                  a_rst,
    axis_rr_arbiter_if.slave      bus,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic                  ovf_clear,
    output logic [NUM_CH-1:0]     ovf_flags,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [DATA_WIDTH-1:0] monitor
);

    localparam int IDW = id_width(NUM_CH);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] slot [NUM_CH];
    logic [NUM_CH-1:0]     pending;
    logic [IDW-1:0]        ptr;

    logic [DATA_WIDTH-1:0] out_tdata;
    logic                  out_tvalid;
    logic [IDW-1:0]        out_tid;

    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     beat;
    logic [NUM_CH-1:0]     grant_oh;
    logic [NUM_CH-1:0]     ovf_ev;
    logic                  grant_valid;
    logic [IDW-1:0]        grant_idx;
    logic [IDW-1:0]        ptr_next;
    logic [CNT_WIDTH-1:0]  ev_count;
    logic [CNT_WIDTH:0]    drop_sum;
    logic [CNT_WIDTH-1:0]  drop_next;

    rr_priority_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .pending     (eligible),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Masking, grant decode, overwrite detection and saturating drop accumulation
    always_comb begin
        eligible = pending & ch_enable;
        beat     = bus.S_AXIS_tvalid & ch_enable;
        grant_oh = '0;
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
        // A granted channel that reloads in the same cycle is not an overwrite
        ovf_ev   = beat & pending & ~grant_oh;
        ev_count = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ev_count = ev_count + CNT_WIDTH'(ovf_ev[k]);
        end
        drop_sum  = {1'b0, drop_count} + {1'b0, ev_count};
        drop_next = drop_sum[CNT_WIDTH] ? CNT_SAT : drop_sum[CNT_WIDTH-1:0];
        ptr_next  = (grant_idx == IDW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Slot/pending update, pointer advance, registered output and overflow bookkeeping
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            pending    <= '0;
            ptr        <= '0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tid    <= '0;
            ovf_flags  <= '0;
            drop_count <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                slot[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (beat[k]) begin
                    slot[k] <= bus.S_AXIS_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            pending <= (eligible & ~grant_oh) | beat;
            if (grant_valid) begin
                ptr        <= ptr_next;
                out_tdata  <= slot[grant_idx];
                out_tid    <= grant_idx;
                out_tvalid <= 1'b1;
            end else begin
                out_tvalid <= 1'b0;
            end
            // Same-cycle overwrites survive a clear
            ovf_flags  <= (ovf_clear ? '0 : ovf_flags) | ovf_ev;
            drop_count <= ovf_clear ? ev_count : drop_next;
        end
    end

    assign bus.M_AXIS_tdata  = out_tdata;
    assign bus.M_AXIS_tvalid = out_tvalid;
    assign bus.M_AXIS_tid    = out_tid;
    assign monitor           = out_tdata;

endmodule
